// File: rtl/line_raster_gen.sv
// line_raster_gen -- Bresenham line rasteriser with a valid/ready pixel stream.
//
// A command carrying two endpoints is accepted over cmd_valid/cmd_ready.
// The block then spends one SETUP cycle deriving the Bresenham terms and
// streams every pixel of the line, endpoints included, on pt_*. The stream
// supports backpressure through pt_ready. pt_last marks the end point, and
// done pulses for one cycle after the final handshake. A synchronous abort
// cancels the line in SETUP or RUN.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   cmd_valid / cmd_ready        command handshake (ready only when idle)
//   cmd_x0, cmd_y0, cmd_x1, cmd_y1  endpoints, COORD_W bits each
//   abort                        cancel the current line (ignored in IDLE)
//   pt_valid / pt_ready          pixel handshake
//   pt_x, pt_y, pt_last          pixel coordinate and end-point flag
//   busy                         high in SETUP or RUN
//   done                         one-cycle pulse after the last pixel
//   pt_idx                       pixel index within the line (only with
//                                LINE_RASTER_IDX_EN defined)
//
// Optional build macro: LINE_RASTER_IDX_EN adds the pt_idx output and its counter.

module line_raster_gen #(
    parameter int COORD_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COORD_W-1:0] cmd_x0,
    input  logic [COORD_W-1:0] cmd_y0,
    input  logic [COORD_W-1:0] cmd_x1,
    input  logic [COORD_W-1:0] cmd_y1,
    input  logic               abort,
    output logic               pt_valid,
    input  logic               pt_ready,
    output logic [COORD_W-1:0] pt_x,
    output logic [COORD_W-1:0] pt_y,
    output logic               pt_last,
    output logic               busy,
`ifdef LINE_RASTER_IDX_EN
    output logic [COORD_W:0]   pt_idx,
`endif
    output logic               done
);

    // Error term: |err| <= 2^COORD_W, so 2*err fits with room to spare.
    localparam int EW = COORD_W + 3;
    typedef logic signed [EW-1:0] err_t;
    localparam logic [COORD_W-1:0] C_ONE = COORD_W'(1);

    typedef enum logic [1:0] {IDLE, SETUP, RUN} state_t;

    state_t             state_q, state_d;
    logic [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
    logic [COORD_W-1:0] x0_d, y0_d, x1_d, y1_d;
    err_t               dx_q, dy_q, err_q, dx_d, dy_d, err_d;
    logic               sx_neg_q, sy_neg_q, sx_neg_d, sy_neg_d;
    logic [COORD_W-1:0] px_q, py_q, px_d, py_d;
    logic               last_q, last_d;
    logic               valid_q, valid_d;
    logic               cmd_rdy_q, cmd_rdy_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [COORD_W:0]   idx_q, idx_d;

    // SETUP-cycle magnitudes from the latched endpoints.
    logic [COORD_W-1:0] absx, absy;
    assign absx = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
    assign absy = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);

    logic               hs;
    err_t               e2, err_n, dx_s, dy_s;
    logic [COORD_W-1:0] nx, ny;

    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        x1_d      = x1_q;
        y1_d      = y1_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        err_d     = err_q;
        sx_neg_d  = sx_neg_q;
        sy_neg_d  = sy_neg_q;
        px_d      = px_q;
        py_d      = py_q;
        last_d    = last_q;
        valid_d   = valid_q;
        cmd_rdy_d = cmd_rdy_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        idx_d     = idx_q;
        hs        = valid_q & pt_ready;
        e2        = err_q <<< 1;
        err_n     = err_q;
        nx        = px_q;
        ny        = py_q;
        dx_s      = err_t'({3'b000, absx});
        dy_s      = -err_t'({3'b000, absy});

        case (state_q)
            IDLE: begin
                // cmd_ready re-arms one cycle after entering IDLE, so a
                // command can never collide with the done pulse.
                cmd_rdy_d = 1'b1;
                if (cmd_valid && cmd_rdy_q) begin
                    x0_d      = cmd_x0;
                    y0_d      = cmd_y0;
                    x1_d      = cmd_x1;
                    y1_d      = cmd_y1;
                    cmd_rdy_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                dx_d     = dx_s;
                dy_d     = dy_s;
                err_d    = dx_s + dy_s;
                sx_neg_d = !(x0_q < x1_q);
                sy_neg_d = !(y0_q < y1_q);
                px_d     = x0_q;
                py_d     = y0_q;
                last_d   = (x0_q == x1_q) && (y0_q == y1_q);
                valid_d  = 1'b1;
                idx_d    = '0;
                state_d  = RUN;
            end
            RUN: begin
                if (hs) begin
                    idx_d = idx_q + 1'b1;
                    if (last_q) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        // Both tests use the pre-update e2.
                        if (e2 >= dy_q) begin
                            err_n = err_n + dy_q;
                            nx    = sx_neg_q ? (px_q - C_ONE) : (px_q + C_ONE);
                        end
                        if (e2 <= dx_q) begin
                            err_n = err_n + dx_q;
                            ny    = sy_neg_q ? (py_q - C_ONE) : (py_q + C_ONE);
                        end
                        err_d  = err_n;
                        px_d   = nx;
                        py_d   = ny;
                        last_d = (nx == x1_q) && (ny == y1_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over any same-cycle handshake; no done pulse.
        if (abort && state_q != IDLE) begin
            state_d   = IDLE;
            valid_d   = 1'b0;
            busy_d    = 1'b0;
            cmd_rdy_d = 1'b1;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            x0_q      <= '0;
            y0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            err_q     <= '0;
            sx_neg_q  <= 1'b0;
            sy_neg_q  <= 1'b0;
            px_q      <= '0;
            py_q      <= '0;
            last_q    <= 1'b0;
            valid_q   <= 1'b0;
            cmd_rdy_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            x1_q      <= x1_d;
            y1_q      <= y1_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            err_q     <= err_d;
            sx_neg_q  <= sx_neg_d;
            sy_neg_q  <= sy_neg_d;
            px_q      <= px_d;
            py_q      <= py_d;
            last_q    <= last_d;
            valid_q   <= valid_d;
            cmd_rdy_q <= cmd_rdy_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            idx_q     <= idx_d;
        end
    end

    assign cmd_ready = cmd_rdy_q;
    assign pt_valid  = valid_q;
    assign pt_x      = px_q;
    assign pt_y      = py_q;
    assign pt_last   = last_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef LINE_RASTER_IDX_EN
    assign pt_idx    = idx_q;
`else
    // Counter has no observer without the index port.
    logic unused_idx;
    assign unused_idx = ^idx_q;
`endif

endmodule

// File: tb/tb_line_raster_gen.sv
module tb_line_raster_gen;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [W-1:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
    logic         abort = 1'b0;
    logic         pt_valid;
    logic         pt_ready = 1'b1;
    logic [W-1:0] pt_x, pt_y;
    logic         pt_last, busy, done;
`ifdef LINE_RASTER_IDX_EN
    logic [W:0]   pt_idx;
`endif

    line_raster_gen #(.COORD_W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
        .abort(abort),
        .pt_valid(pt_valid), .pt_ready(pt_ready),
        .pt_x(pt_x), .pt_y(pt_y), .pt_last(pt_last),
        .busy(busy),
`ifdef LINE_RASTER_IDX_EN
        .pt_idx(pt_idx),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    // Command record: endpoints, expected pixel count, expected pixels packed
    // as one byte {x,y} each, first pixel in the most significant used byte.
    typedef struct {
        logic [3:0]   x0, y0, x1, y1;
        int           n;
        logic [127:0] pix;
    } vec_t;

    typedef struct {
        int x, y, last, idx;
    } px_t;

    vec_t tbl [7];
    px_t  q [$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int done_exp = 0;
    int stall_prev = 0;
    int sx, sy, sl, si;

    always @(negedge clk) begin
        if (!rst_n) begin
            done_exp   = 0;
            stall_prev = 0;
        end else begin
            chk("done", int'(done), done_exp);
            if (stall_prev != 0) begin
                chk("stall_valid", int'(pt_valid), 1);
                chk("stall_x", int'(pt_x), sx);
                chk("stall_y", int'(pt_y), sy);
                chk("stall_last", int'(pt_last), sl);
`ifdef LINE_RASTER_IDX_EN
                chk("stall_idx", int'(pt_idx), si);
`endif
            end
            if (pt_valid && pt_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_pixel: got (%0d,%0d) expected none", pt_x, pt_y);
                end else begin
                    px_t e;
                    e = q.pop_front();
                    chk("pix_x", int'(pt_x), e.x);
                    chk("pix_y", int'(pt_y), e.y);
                    chk("pix_last", int'(pt_last), e.last);
`ifdef LINE_RASTER_IDX_EN
                    chk("pix_idx", int'(pt_idx), e.idx);
`endif
                end
            end
            done_exp   = (pt_valid && pt_ready && pt_last && !abort) ? 1 : 0;
            stall_prev = (pt_valid && !pt_ready && !abort) ? 1 : 0;
            sx = int'(pt_x);
            sy = int'(pt_y);
            sl = int'(pt_last);
`ifdef LINE_RASTER_IDX_EN
            si = int'(pt_idx);
`else
            si = 0;
`endif
        end
    end

    // ---------------- driver tasks ----------------
    // Push the expected pixels, present the command, check the 2-cycle latency.
    task automatic send(input vec_t v);
        bit ok = 0;
        for (int k = 0; k < v.n; k++) begin
            px_t e;
            logic [7:0] b;
            b = v.pix[8*(v.n-1-k) +: 8];
            e.x = int'(b[7:4]);
            e.y = int'(b[3:0]);
            e.last = (k == v.n - 1) ? 1 : 0;
            e.idx = k;
            q.push_back(e);
        end
        @(posedge clk); #1;
        cmd_x0 = v.x0; cmd_y0 = v.y0; cmd_x1 = v.x1; cmd_y1 = v.y1;
        cmd_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            chk("cmd_ready_timeout", 0, 1);
            cmd_valid = 1'b0;
            q.delete();
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("setup_busy", int'(busy), 1);
        chk("setup_valid", int'(pt_valid), 0);
        chk("setup_ready", int'(cmd_ready), 0);
        @(negedge clk);
        chk("first_valid", int'(pt_valid), 1);
    endtask

    // Wait for the scoreboard to drain; returns posedges spent.
    task automatic drain(output int cnt);
        cnt = 0;
        while (q.size() != 0 && cnt < 300) begin
            @(posedge clk);
            cnt++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    // After the last handshake: done cycle has cmd_ready low, then it rises.
    task automatic finish_line();
        @(negedge clk);
        chk("done_cycle_ready", int'(cmd_ready), 0);
        chk("done_cycle_valid", int'(pt_valid), 0);
        @(negedge clk);
        chk("idle_ready", int'(cmd_ready), 1);
        chk("idle_busy", int'(busy), 0);
    endtask

    task automatic run_line(input vec_t v);
        int cnt;
        send(v);
        drain(cnt);
        chk("throughput", cnt, v.n);
        finish_line();
    endtask

    task automatic wait_q_le(input int lim);
        int t = 0;
        while (q.size() > lim && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (q.size() > lim) chk("progress_timeout", q.size(), lim);
    endtask

    initial begin
        int cnt;
        tbl[0] = '{x0:0, y0:0, x1:5, y1:2, n:6,  pix:128'h001021314252};
        tbl[1] = '{x0:5, y0:2, x1:0, y1:0, n:6,  pix:128'h524231211000};
        tbl[2] = '{x0:2, y0:1, x1:2, y1:6, n:6,  pix:128'h212223242526};
        tbl[3] = '{x0:0, y0:0, x1:15, y1:15, n:16, pix:128'h00112233445566778899AABBCCDDEEFF};
        tbl[4] = '{x0:7, y0:7, x1:7, y1:7, n:1,  pix:128'h77};
        tbl[5] = '{x0:0, y0:0, x1:2, y1:5, n:6,  pix:128'h000112132425};
        tbl[6] = '{x0:1, y0:1, x1:3, y1:1, n:3,  pix:128'h112131};

        // Reset values
        #12;
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_valid", int'(pt_valid), 0);
        chk("rst_x", int'(pt_x), 0);
        chk("rst_y", int'(pt_y), 0);
        chk("rst_last", int'(pt_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Table-driven lines with pt_ready held high
        for (int i = 0; i < 6; i++) run_line(tbl[i]);

        // Backpressure: stall 3 cycles while the third pixel (2,1) is shown
        send(tbl[0]);
        wait_q_le(4);
        #1 pt_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 pt_ready = 1'b1;
        drain(cnt);
        finish_line();

        // Abort after two handshakes; the same-cycle third pixel is consumed
        send(tbl[0]);
        wait_q_le(4);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        q.delete();
        @(negedge clk);
        chk("abort_valid", int'(pt_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(cmd_ready), 1);
        run_line(tbl[6]);

        // Abort in IDLE is ignored
        #1 abort = 1'b1;
        @(negedge clk);
        chk("idle_abort_ready", int'(cmd_ready), 1);
        chk("idle_abort_busy", int'(busy), 0);
        @(posedge clk); #1;
        abort = 1'b0;

        // Asynchronous reset mid-line
        send(tbl[3]);
        wait_q_le(10);
        #1 rst_n = 1'b0;
        #2;
        chk("arst_cmd_ready", int'(cmd_ready), 1);
        chk("arst_valid", int'(pt_valid), 0);
        chk("arst_x", int'(pt_x), 0);
        chk("arst_y", int'(pt_y), 0);
        chk("arst_last", int'(pt_last), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_line(tbl[0]);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
